// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the data-memory stage controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic logic [3:0] gen_be(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: gen_be = 4'b0001 << offset;
      SIZE_HALF: gen_be = 4'b0011 << {offset[1], 1'b0};
      default:   gen_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: replicate_wdata = {4{data[7:0]}};
      SIZE_HALF: replicate_wdata = {2{data[15:0]}};
      default:   replicate_wdata = data;
    endcase
  endfunction

  // Low address bits that survive for a given access size.
  function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: align_offset = offset;
      SIZE_HALF: align_offset = {offset[1], 1'b0};
      default:   align_offset = 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = offset[0];
      default:   misaligned = |offset;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/gnt/rvalid port bundle.
interface mem_stage_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/load_align.sv
// Combinational load lane select and sign/zero extension.
module load_align
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] lane;

  assign lane = rdata >> {offset, 3'b000};

  always_comb begin
    case (size)
      SIZE_BYTE: data = is_unsigned ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      SIZE_HALF: data = is_unsigned ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default:   data = lane;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Data-memory access sequencer for the EX/MEM instruction.
// Optional misaligned-access trap enabled with MEM_MISALIGN_TRAP_EN.
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    is_load,
  input  logic                    mem_write,
  input  logic [2:0]              load_type,
  input  logic                    load_unsigned,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  input  logic                    flush,
  mem_stage_ctrl_if.master        dmem,
  output logic                    stall,
  output logic                    load_valid,
  output logic [31:0]             load_data,
  output logic                    bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  , output logic                  misalign_err
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             kill;
  logic             access, start, timeout;
  logic [1:0]       size, eff_off;
  logic             unused;

  logic             ld_q, we_q, uns_q;
  logic [1:0]       size_q, off_q;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       be_q;
  logic [31:0]      aligned;
  logic [31:0]      load_data_q;

  assign unused  = load_type[2];
  assign size    = load_type[1:0];
  assign eff_off = align_offset(size, addr[1:0]);
  assign access  = (is_load | mem_write) & ~flush;
  assign timeout = (cnt == CNT_LAST);

`ifdef MEM_MISALIGN_TRAP_EN
  logic bad_align;
  assign bad_align    = misaligned(size, addr[1:0]);
  assign start        = access & ~bad_align;
  assign misalign_err = (state == IDLE) & access & bad_align;
`else
  assign start = access;
`endif

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    bus_err   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = REQ;
          stall     = 1'b1;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dmem.gnt) begin
          state_nxt = ld_q ? WAIT : DONE;
        end else if (timeout) begin
          bus_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem.rvalid) begin
          state_nxt = DONE;
        end else if (timeout) begin
          bus_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      kill        <= 1'b0;
      load_data_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == REQ || state == WAIT) ? cnt + 1'b1 : '0;
      // Bus cannot cancel, so a flush only marks the result as dead.
      if (state == IDLE)
        kill <= 1'b0;
      else if ((state == REQ || state == WAIT) && flush)
        kill <= 1'b1;
      if (state == WAIT && dmem.rvalid)
        load_data_q <= aligned;
    end
  end

  // Access attributes frozen at IDLE->REQ
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      ld_q    <= is_load;
      we_q    <= mem_write & ~is_load;
      uns_q   <= load_unsigned;
      size_q  <= size;
      off_q   <= eff_off;
      addr_q  <= {addr[31:2], 2'b00};
      be_q    <= gen_be(size, eff_off);
      wdata_q <= replicate_wdata(size, wdata);
    end
  end

  load_align u_load_align (
    .rdata       (dmem.rdata),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (aligned)
  );

  assign dmem.req   = (state == REQ) & rst_n;
  assign dmem.we    = (state == REQ) & we_q;
  assign dmem.addr  = (state == REQ) ? addr_q  : '0;
  assign dmem.be    = (state == REQ) ? be_q    : '0;
  assign dmem.wdata = (state == REQ) ? wdata_q : '0;

  assign load_valid = (state == DONE) & ld_q & ~kill;
  assign load_data  = load_data_q;

endmodule
